// File: rtl/ac97_codec_link.sv
// ac97_codec_link
//   Codec-side AC'97 link engine. Deframes the controller's output stream
//   (ac97_sync / ac97_sout), services slot 1/2 register commands against a
//   64x16 register file, and frames the codec's input stream on ac97_sin
//   (tag, status address/data, capture PCM in slots 3/4).
//
// Ports
//   ac97_clk, ac97_rst_n          bit clock (rising edge), async active-low reset
//   ac97_sync, ac97_sout          frame sync / serial data from controller
//   ac97_sin                      serial data to controller
//   codec_ready                   mirrors outgoing tag bit 15
//   sync_err                      one-cycle pulse on a framing error
//   pcm_out_stb/left/right        playback pair from slots 3/4, strobe on update
//   pcm_in_valid/left/right       capture pair offered for slots 3/4
//   pcm_in_ack                    one-cycle pulse when the capture pair is sent
//
// Build option
//   AC97_CODEC_LOOPBACK_EN : when defined and register 0x20 bit 7 is set, the
//   capture slots echo the latest playback pair instead of pcm_in_*.
module ac97_codec_link #(
   parameter logic [15:0] VENDOR_ID1   = 16'h4D4D,
   parameter logic [15:0] VENDOR_ID2   = 16'h4D01,
   parameter int unsigned READY_FRAMES = 4
) (
   input  logic        ac97_clk,
   input  logic        ac97_rst_n,
   input  logic        ac97_sync,
   input  logic        ac97_sout,
   output logic        ac97_sin,
   output logic        codec_ready,
   output logic        sync_err,
   output logic        pcm_out_stb,
   output logic [19:0] pcm_out_left,
   output logic [19:0] pcm_out_right,
   input  logic        pcm_in_valid,
   input  logic [19:0] pcm_in_left,
   input  logic [19:0] pcm_in_right,
   output logic        pcm_in_ack
);

   typedef enum logic {StHunt, StRun} state_e;

   localparam logic [7:0] ReadyFrames = 8'(READY_FRAMES);
   localparam logic [5:0] IdxVid1     = 6'h3E;
   localparam logic [5:0] IdxVid2     = 6'h3F;

   function automatic logic [15:0] reg_default(input logic [5:0] ridx);
      logic [15:0] val;
      case (ridx)
         IdxVid1: val = VENDOR_ID1;
         IdxVid2: val = VENDOR_ID2;
         default: val = 16'h0000;
      endcase
      return val;
   endfunction

   state_e        state_q, state_d;
   logic          sync_q, sout_q, sync_prev_q;
   logic [7:0]    bit_cnt_q, bit_cnt_d;
   logic [18:0]   shift_q, shift_d;        // last 19 received bits; with sout_q forms a slot
   logic [4:0]    tag_q, tag_d;            // {valid, slot1..slot4 valid}
   logic          wr_q, wr_d;
   logic [5:0]    wr_idx_q, wr_idx_d;
   logic          pend_q, pend_d;
   logic [6:0]    pend_addr_q, pend_addr_d;
   logic [19:0]   play_left_q, play_left_d;
   logic [94:0]   out_shift_q, out_shift_d;
   logic          sin_q, sin_d;
   logic [7:0]    rdy_cnt_q, rdy_cnt_d;
   logic          codec_ready_q, codec_ready_d;
   logic          sync_err_q, sync_err_d;
   logic          pcm_out_stb_q, pcm_out_stb_d;
   logic [19:0]   pcm_out_left_q, pcm_out_left_d;
   logic [19:0]   pcm_out_right_q, pcm_out_right_d;
   logic          pcm_in_ack_q, pcm_in_ack_d;
   logic [15:0]   regs_q [64];

`ifdef AC97_CODEC_LOOPBACK_EN
   logic          play_valid_q, play_valid_d;
`endif

   logic          frame_start, active;
   logic [7:0]    idx;
   logic          reg_we, reg_restore;
   logic [15:0]   reg_wdata;
   logic [6:0]    reply_addr;
   logic [15:0]   reply_data;
   logic          cap_valid, cap_from_in;
   logic [19:0]   cap_left, cap_right;
   logic [95:0]   image;

   always_comb begin
      state_d         = state_q;
      bit_cnt_d       = bit_cnt_q;
      shift_d         = shift_q;
      tag_d           = tag_q;
      wr_d            = wr_q;
      wr_idx_d        = wr_idx_q;
      pend_d          = pend_q;
      pend_addr_d     = pend_addr_q;
      play_left_d     = play_left_q;
      out_shift_d     = out_shift_q;
      sin_d           = 1'b0;
      rdy_cnt_d       = rdy_cnt_q;
      codec_ready_d   = codec_ready_q;
      sync_err_d      = 1'b0;
      pcm_out_stb_d   = 1'b0;
      pcm_out_left_d  = pcm_out_left_q;
      pcm_out_right_d = pcm_out_right_q;
      pcm_in_ack_d    = 1'b0;
      reg_we          = 1'b0;
      reg_restore     = 1'b0;
      reg_wdata       = shift_q[18:3];
      active          = 1'b0;
      idx             = bit_cnt_q;
      frame_start     = sync_q & ~sync_prev_q;

      reply_addr  = pend_q ? pend_addr_q : 7'd0;
      reply_data  = pend_q ? regs_q[pend_addr_q[6:1]] : 16'h0000;
      cap_valid   = pcm_in_valid & codec_ready_q;
      cap_left    = pcm_in_left;
      cap_right   = pcm_in_right;
      cap_from_in = 1'b1;
`ifdef AC97_CODEC_LOOPBACK_EN
      play_valid_d = play_valid_q;
      if (regs_q[6'h10][7]) begin
         cap_valid   = play_valid_q;
         cap_left    = pcm_out_left_q;
         cap_right   = pcm_out_right_q;
         cap_from_in = 1'b0;
      end
`endif
      // Slot 1 request field 11:2 is active-low: only slots 3/4 requested.
      image = {codec_ready_q, pend_q, pend_q, cap_valid, cap_valid, 11'd0,
               1'b0, reply_addr, 10'b0011111111, 2'b00,
               reply_data, 4'd0,
               cap_left,
               cap_right};

      case (state_q)
         StHunt: begin
            if (frame_start) begin
               state_d   = StRun;
               bit_cnt_d = 8'd1;
               active    = 1'b1;
               idx       = 8'd0;
            end
         end
         StRun: begin
            if (frame_start) begin
               // Either the expected wrap or a realignment; both restart at bit 0.
               active    = 1'b1;
               idx       = 8'd0;
               bit_cnt_d = 8'd1;
               if (bit_cnt_q != 8'd0) sync_err_d = 1'b1;
            end else if (bit_cnt_q == 8'd0) begin
               sync_err_d = 1'b1;
               state_d    = StHunt;
            end else begin
               active    = 1'b1;
               bit_cnt_d = bit_cnt_q + 8'd1;
            end
         end
         default: state_d = StHunt;
      endcase

      if (active) begin
         shift_d = {shift_q[17:0], sout_q};

         if (idx == 8'd0) begin
            // New frame: drop any partial decode, launch the reply image.
            tag_d       = 5'd0;
            wr_d        = 1'b0;
            sin_d       = image[95];
            out_shift_d = image[94:0];
            pend_d      = 1'b0;
            pcm_in_ack_d = cap_from_in & cap_valid;
`ifdef AC97_CODEC_LOOPBACK_EN
            if (!cap_from_in) play_valid_d = 1'b0;
`endif
         end else begin
            sin_d       = out_shift_q[94];
            out_shift_d = {out_shift_q[93:0], 1'b0};
         end

         if (idx == 8'd15) tag_d = shift_q[14:10];

         if (idx == 8'd35) begin
            wr_d     = tag_q[4] & tag_q[3] & tag_q[2] & ~shift_q[18];
            wr_idx_d = shift_q[17:12];
            if (tag_q[4] & tag_q[3] & shift_q[18]) begin
               pend_d      = 1'b1;
               pend_addr_d = shift_q[17:11];
            end
         end

         if (idx == 8'd55 && wr_q) begin
            if (wr_idx_q == 6'h00) begin
               reg_restore = 1'b1;
            end else if (wr_idx_q != IdxVid1 && wr_idx_q != IdxVid2) begin
               reg_we = 1'b1;
            end
         end

         if (idx == 8'd75) play_left_d = {shift_q, sout_q};

         if (idx == 8'd95 && tag_q[4] && tag_q[1] && tag_q[0]) begin
            pcm_out_left_d  = play_left_q;
            pcm_out_right_d = {shift_q, sout_q};
            pcm_out_stb_d   = 1'b1;
`ifdef AC97_CODEC_LOOPBACK_EN
            play_valid_d    = 1'b1;
`endif
         end

         if (idx == 8'd255 && rdy_cnt_q < ReadyFrames) rdy_cnt_d = rdy_cnt_q + 8'd1;
      end else begin
         out_shift_d = '0;
      end

      codec_ready_d = (rdy_cnt_d >= ReadyFrames);
   end

   always_ff @(posedge ac97_clk or negedge ac97_rst_n) begin
      if (!ac97_rst_n) begin
         state_q         <= StHunt;
         sync_q          <= 1'b0;
         sout_q          <= 1'b0;
         sync_prev_q     <= 1'b0;
         bit_cnt_q       <= 8'd0;
         shift_q         <= '0;
         tag_q           <= '0;
         wr_q            <= 1'b0;
         wr_idx_q        <= '0;
         pend_q          <= 1'b0;
         pend_addr_q     <= '0;
         play_left_q     <= '0;
         out_shift_q     <= '0;
         sin_q           <= 1'b0;
         rdy_cnt_q       <= 8'd0;
         codec_ready_q   <= 1'b0;
         sync_err_q      <= 1'b0;
         pcm_out_stb_q   <= 1'b0;
         pcm_out_left_q  <= '0;
         pcm_out_right_q <= '0;
         pcm_in_ack_q    <= 1'b0;
`ifdef AC97_CODEC_LOOPBACK_EN
         play_valid_q    <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         sync_q          <= ac97_sync;
         sout_q          <= ac97_sout;
         sync_prev_q     <= sync_q;
         bit_cnt_q       <= bit_cnt_d;
         shift_q         <= shift_d;
         tag_q           <= tag_d;
         wr_q            <= wr_d;
         wr_idx_q        <= wr_idx_d;
         pend_q          <= pend_d;
         pend_addr_q     <= pend_addr_d;
         play_left_q     <= play_left_d;
         out_shift_q     <= out_shift_d;
         sin_q           <= sin_d;
         rdy_cnt_q       <= rdy_cnt_d;
         codec_ready_q   <= codec_ready_d;
         sync_err_q      <= sync_err_d;
         pcm_out_stb_q   <= pcm_out_stb_d;
         pcm_out_left_q  <= pcm_out_left_d;
         pcm_out_right_q <= pcm_out_right_d;
         pcm_in_ack_q    <= pcm_in_ack_d;
`ifdef AC97_CODEC_LOOPBACK_EN
         play_valid_q    <= play_valid_d;
`endif
      end
   end

   // Register file; the vendor ID entries are never write targets.
   always_ff @(posedge ac97_clk or negedge ac97_rst_n) begin
      if (!ac97_rst_n) begin
         for (int i = 0; i < 64; i++) regs_q[i] <= reg_default(6'(i));
      end else if (reg_restore) begin
         for (int i = 0; i < 64; i++) regs_q[i] <= reg_default(6'(i));
      end else if (reg_we) begin
         regs_q[wr_idx_q] <= reg_wdata;
      end
   end

   assign ac97_sin      = sin_q;
   assign codec_ready   = codec_ready_q;
   assign sync_err      = sync_err_q;
   assign pcm_out_stb   = pcm_out_stb_q;
   assign pcm_out_left  = pcm_out_left_q;
   assign pcm_out_right = pcm_out_right_q;
   assign pcm_in_ack    = pcm_in_ack_q;

endmodule
